// File: rtl/capa_transaccion_param.sv
// capa_transaccion_param: parametrised transaction layer.
// Packets enter one entry queue, are sorted by class into N class queues (stage 1), and a
// round-robin arbiter forwards class-queue heads by destination into N output queues (stage 2).
// Also holds the threshold-programming FSM, per-port packet counters and the upstream
// full/overflow handshake.
// Ports:
//   clk, reset (async, active-low)
//   init, umbral_bajo, umbral_alto : threshold programming
//   in_data, push, in_full, overflow : entry side
//   pop, out_data, out_empty, out_almost_empty : N show-ahead output queues
//   req, idx, cnt_data, cnt_valid : counter read port (idx == N selects entry pushes)
//   idle : FSM is in IDLE
module capa_transaccion_param #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned N      = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 5,
  localparam int unsigned CW    = $clog2(N),
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned IW    = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [AW:0]           umbral_bajo,
  input  logic [AW:0]           umbral_alto,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  push,
  output logic                  in_full,
  output logic                  overflow,
  input  logic [N-1:0]          pop,
  output logic [N*DATA_W-1:0]   out_data,
  output logic [N-1:0]          out_empty,
  output logic [N-1:0]          out_almost_empty,
  input  logic                  req,
  input  logic [IW-1:0]         idx,
  output logic [CNT_W-1:0]      cnt_data,
  output logic                  cnt_valid,
  output logic                  idle
);

  // Queue map: 0 = entry, 1..N = class queues, N+1..2N = output queues.
  localparam int unsigned Q  = 2 * N + 1;
  localparam int unsigned OB = N + 1;

  typedef enum logic [1:0] {StReset, StInit, StIdle, StActive} state_e;

  state_e                 state_q;
  logic [DATA_W-1:0]      mem_q    [Q][DEPTH];
  logic [AW-1:0]          rd_ptr_q [Q];
  logic [AW-1:0]          wr_ptr_q [Q];
  logic [AW:0]            count_q  [Q];
  logic [AW:0]            count_d  [Q];
  logic [DATA_W-1:0]      head     [Q];
  logic [DATA_W-1:0]      q_wdata  [Q];
  logic [Q-1:0]           q_empty, q_full, q_block, q_push, q_pop;

  logic [AW:0]            alto_q, bajo_q;
  logic [CNT_W-1:0]       pkt_cnt_q [N+1];
  logic [CNT_W-1:0]       cnt_data_q;
  logic                   cnt_valid_q, overflow_q, idle_q;
  logic [CW-1:0]          rr_q;

  logic                   xfer_en, grant, any_next;
  logic [CW-1:0]          win, rr_j;
  logic [N-1:0]           cand;
  logic [DATA_W-1:0]      s2_data;

  assign xfer_en = (state_q == StIdle) || (state_q == StActive);

  // Per-queue status; "blocked" covers both almost-full and a hard full in case the
  // programmed threshold exceeds the depth.
  always_comb begin
    for (int q = 0; q < Q; q++) begin
      head[q]    = mem_q[q][rd_ptr_q[q]];
      q_empty[q] = (count_q[q] == '0);
      q_full[q]  = (count_q[q] == (AW+1)'(DEPTH));
      q_block[q] = q_full[q] || (count_q[q] >= alto_q);
    end
  end

  // Stage-2 candidates and round-robin pick starting at rr_q.
  always_comb begin
    cand  = '0;
    grant = 1'b0;
    win   = '0;
    rr_j  = '0;
    for (int i = 0; i < N; i++) begin
      cand[i] = !q_empty[1+i];
      for (int d = 0; d < N; d++) begin
        if (head[1+i][DATA_W-CW-1 -: CW] == CW'(d) && q_block[OB+d]) cand[i] = 1'b0;
      end
    end
    for (int off = 0; off < N; off++) begin
      rr_j = rr_q + CW'(off);
      if (!grant && cand[rr_j]) begin
        grant = 1'b1;
        win   = rr_j;
      end
    end
  end

  // Push/pop decode for every queue.
  always_comb begin
    q_push  = '0;
    q_pop   = '0;
    s2_data = '0;
    for (int q = 0; q < Q; q++) q_wdata[q] = '0;

    q_push[0]  = push && !q_full[0];
    q_wdata[0] = in_data;

    for (int i = 0; i < N; i++) begin
      if (xfer_en && !q_empty[0] && head[0][DATA_W-1 -: CW] == CW'(i) && !q_block[1+i]) begin
        q_pop[0]     = 1'b1;
        q_push[1+i]  = 1'b1;
        q_wdata[1+i] = head[0];
      end
    end

    if (xfer_en && grant) begin
      for (int i = 0; i < N; i++) begin
        if (win == CW'(i)) begin
          q_pop[1+i] = 1'b1;
          s2_data    = head[1+i];
        end
      end
      for (int d = 0; d < N; d++) begin
        if (s2_data[DATA_W-CW-1 -: CW] == CW'(d)) begin
          q_push[OB+d]  = 1'b1;
          q_wdata[OB+d] = s2_data;
        end
      end
    end

    for (int i = 0; i < N; i++) begin
      if (pop[i] && !q_empty[OB+i]) q_pop[OB+i] = 1'b1;
    end
  end

  always_comb begin
    any_next = 1'b0;
    for (int q = 0; q < Q; q++) begin
      count_d[q] = count_q[q];
      if (q_push[q] && !q_pop[q])      count_d[q] = count_q[q] + 1'b1;
      else if (q_pop[q] && !q_push[q]) count_d[q] = count_q[q] - 1'b1;
      if (count_d[q] != '0) any_next = 1'b1;
    end
  end

  // Storage needs no reset: an empty queue never exposes its contents.
  always_ff @(posedge clk) begin
    for (int q = 0; q < Q; q++) begin
      if (q_push[q]) mem_q[q][wr_ptr_q[q]] <= q_wdata[q];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int q = 0; q < Q; q++) begin
        rd_ptr_q[q] <= '0;
        wr_ptr_q[q] <= '0;
        count_q[q]  <= '0;
      end
    end else begin
      for (int q = 0; q < Q; q++) begin
        if (q_push[q]) wr_ptr_q[q] <= wr_ptr_q[q] + 1'b1;
        if (q_pop[q])  rd_ptr_q[q] <= rd_ptr_q[q] + 1'b1;
        count_q[q] <= count_d[q];
      end
    end
  end

  // Control FSM with thresholds, counters, arbiter pointer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StReset;
      alto_q      <= (AW+1)'(DEPTH - 1);
      bajo_q      <= (AW+1)'(1);
      overflow_q  <= 1'b0;
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
      idle_q      <= 1'b0;
      rr_q        <= '0;
      for (int i = 0; i <= N; i++) pkt_cnt_q[i] <= '0;
    end else begin
      cnt_valid_q <= 1'b0;
      for (int i = 0; i <= N; i++) begin
        if (req && idx == IW'(i)) begin
          cnt_valid_q <= 1'b1;
          cnt_data_q  <= pkt_cnt_q[i];
        end
      end

      if (q_push[0]) pkt_cnt_q[N] <= pkt_cnt_q[N] + 1'b1;
      for (int d = 0; d < N; d++) begin
        if (q_push[OB+d]) pkt_cnt_q[d] <= pkt_cnt_q[d] + 1'b1;
      end

      if (xfer_en && grant) rr_q <= win + CW'(1);

      unique case (state_q)
        StReset: begin
          idle_q <= 1'b0;
          if (init) state_q <= StInit;
        end
        StInit: begin
          alto_q     <= umbral_alto;
          bajo_q     <= umbral_bajo;
          overflow_q <= 1'b0;
          for (int i = 0; i <= N; i++) pkt_cnt_q[i] <= '0;
          if (!init) begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end
        end
        StIdle, StActive: begin
          if (init) begin
            state_q <= StInit;
            idle_q  <= 1'b0;
          end else if (any_next) begin
            state_q <= StActive;
            idle_q  <= 1'b0;
          end else begin
            state_q <= StIdle;
            idle_q  <= 1'b1;
          end
        end
        default: state_q <= StReset;
      endcase

      // A dropped push is recorded even while INIT is clearing the flag.
      if (push && q_full[0]) overflow_q <= 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      out_data[i*DATA_W +: DATA_W] = q_empty[OB+i] ? '0 : head[OB+i];
      out_empty[i]                 = q_empty[OB+i];
      out_almost_empty[i]          = (count_q[OB+i] <= bajo_q);
    end
  end

  assign in_full   = q_full[0];
  assign overflow  = overflow_q;
  assign cnt_data  = cnt_data_q;
  assign cnt_valid = cnt_valid_q;
  assign idle      = idle_q;

endmodule
